// File: rtl/issue_wakeup_arb.sv
// Four per-source result FIFOs feeding a two-port round-robin registered wake-up broadcaster; handshake to broadcast is 2 cycles.
// src_ready drops only while a source FIFO is full (no push-through); optional flush port via ISSUE_WAKEUP_FLUSH_EN.

module wakeup_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 36
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         not_empty,
  output logic         not_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  assign head_dat  = mem[rd_ptr];
  assign not_empty = (count != '0);
  assign not_full  = (count != CW'(DEPTH));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end
endmodule

module issue_wakeup_arb #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [3:0]   src_valid,
  output logic [3:0]   src_ready,
  input  logic [15:0]  src_rob,
  input  logic [127:0] src_value,
  output logic         wea,
  output logic [3:0]   dina_rob,
  output logic [31:0]  dina_value,
  output logic         web,
  output logic [3:0]   dinb_rob,
  output logic [31:0]  dinb_value
`ifdef ISSUE_WAKEUP_FLUSH_EN
  ,
  input  logic         flush
`endif
);
  typedef struct packed {
    logic [3:0]  rob;
    logic [31:0] value;
  } wk_ent_t;

  logic       flush_act;
  wk_ent_t    head [4];
  logic [3:0] not_empty;
  logic [3:0] not_full;
  logic [3:0] push;
  logic [3:0] pop;
  logic [1:0] rr_ptr;
  logic [1:0] cand;
  logic       gnt_a;
  logic       gnt_b;
  logic [1:0] idx_a;
  logic [1:0] idx_b;

`ifdef ISSUE_WAKEUP_FLUSH_EN
  assign flush_act = flush;
`else
  assign flush_act = 1'b0;
`endif

  // Ready comes from registered occupancy only, so a same-cycle pop never reopens a full FIFO.
  assign src_ready = not_full & {4{~flush_act}};
  assign push      = src_valid & src_ready;

  for (genvar i = 0; i < 4; i++) begin : g_src
    wakeup_fifo #(
      .DEPTH(FIFO_DEPTH),
      .W($bits(wk_ent_t))
    ) u_fifo (
      .clk      (clk),
      .resetn   (resetn),
      .clr      (flush_act),
      .push     (push[i]),
      .push_dat ({src_rob[4*i +: 4], src_value[32*i +: 32]}),
      .pop      (pop[i]),
      .head_dat (head[i]),
      .not_empty(not_empty[i]),
      .not_full (not_full[i])
    );
  end

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    idx_a = rr_ptr;
    idx_b = rr_ptr;
    cand  = rr_ptr;
    for (int k = 0; k < 4; k++) begin
      cand = rr_ptr + 2'(k);
      if (not_empty[cand]) begin
        if (!gnt_a) begin
          gnt_a = 1'b1;
          idx_a = cand;
        end else if (!gnt_b) begin
          gnt_b = 1'b1;
          idx_b = cand;
        end
      end
    end
  end

  always_comb begin
    pop = '0;
    if (gnt_a) pop[idx_a] = 1'b1;
    if (gnt_b) pop[idx_b] = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr     <= '0;
      wea        <= 1'b0;
      web        <= 1'b0;
      dina_rob   <= '0;
      dina_value <= '0;
      dinb_rob   <= '0;
      dinb_value <= '0;
    end else if (flush_act) begin
      // Flush wins over this cycle's grants; data registers keep their last broadcast.
      rr_ptr <= '0;
      wea    <= 1'b0;
      web    <= 1'b0;
    end else begin
      wea <= gnt_a;
      web <= gnt_b;
      if (gnt_a) begin
        dina_rob   <= head[idx_a].rob;
        dina_value <= head[idx_a].value;
      end
      if (gnt_b) begin
        dinb_rob   <= head[idx_b].rob;
        dinb_value <= head[idx_b].value;
      end
      if (gnt_b)      rr_ptr <= idx_b + 2'd1;
      else if (gnt_a) rr_ptr <= idx_a + 2'd1;
    end
  end
endmodule

// File: tb/tb_issue_wakeup_arb.sv
// Bench for issue_wakeup_arb: directed vector table, hand sequences and random traffic against a queue-based model.
module tb_issue_wakeup_arb;
  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         resetn;
  logic [3:0]   src_valid;
  logic [3:0]   src_ready;
  logic [15:0]  src_rob;
  logic [127:0] src_value;
  logic         wea;
  logic         web;
  logic [3:0]   dina_rob;
  logic [3:0]   dinb_rob;
  logic [31:0]  dina_value;
  logic [31:0]  dinb_value;
  logic         flush;

  int checks = 0;
  int errors = 0;

  issue_wakeup_arb #(.FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_rob   (src_rob),
    .src_value (src_value),
    .wea       (wea),
    .dina_rob  (dina_rob),
    .dina_value(dina_value),
    .web       (web),
    .dinb_rob  (dinb_rob),
    .dinb_value(dinb_value)
`ifdef ISSUE_WAKEUP_FLUSH_EN
    ,
    .flush     (flush)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  rob;
    logic [31:0] val;
  } ent_t;

  typedef struct {
    logic [3:0]   v;
    logic [15:0]  rob;
    logic [127:0] val;
    logic [73:0]  exp;
  } vec_t;

  ent_t mq[4][$];
  int   m_rr;
  logic m_wea;
  logic m_web;
  ent_t m_a;
  ent_t m_b;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] outv();
    return {54'd0, wea, web, dina_rob, dina_value, dinb_rob, dinb_value};
  endfunction

  function automatic logic [127:0] m_outv();
    return {54'd0, m_wea, m_web, m_a, m_b};
  endfunction

  function automatic logic [3:0] m_ready(input logic fl);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = !fl && (mq[i].size() < DEPTH);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mq[i].delete();
    m_rr  = 0;
    m_wea = 1'b0;
    m_web = 1'b0;
    m_a   = '0;
    m_b   = '0;
  endtask

  // One clock edge of the reference: grants from pre-edge contents, then pops, then accepted pushes.
  task automatic model_edge(input logic [3:0] v, input logic [15:0] r, input logic [127:0] d, input logic fl);
    logic [3:0] acc;
    int g[$];
    int s;
    acc = v & m_ready(fl);
    if (fl) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
      m_rr  = 0;
      m_wea = 1'b0;
      m_web = 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        s = (m_rr + k) % 4;
        if (mq[s].size() > 0 && g.size() < 2) g.push_back(s);
      end
      m_wea = (g.size() > 0);
      m_web = (g.size() > 1);
      if (m_wea) m_a = mq[g[0]].pop_front();
      if (m_web) m_b = mq[g[1]].pop_front();
      if (g.size() > 0) m_rr = (g[g.size()-1] + 1) % 4;
      for (int i = 0; i < 4; i++)
        if (acc[i]) mq[i].push_back({r[4*i +: 4], d[32*i +: 32]});
    end
  endtask

  task automatic cycle(input logic [3:0] v, input logic [15:0] r, input logic [127:0] d, input logic fl);
    src_valid = v;
    src_rob   = r;
    src_value = d;
    flush     = fl;
    #1;
    chk("ready", 128'(src_ready), 128'(m_ready(fl)));
    model_edge(v, r, d, fl);
    @(posedge clk);
    #1;
    chk("bcast", outv(), m_outv());
    src_valid = '0;
    flush     = 1'b0;
  endtask

  // Reset pulse placed between clock edges; outputs must clear without any edge.
  task automatic do_reset();
    src_valid = '0;
    flush     = 1'b0;
    #1 resetn = 1'b0;
    #1;
    chk("rst_out", outv(), 128'd0);
    chk("rst_rdy", 128'(src_ready), 128'(4'hF));
    #1 resetn = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  vec_t         tbl[10];
  logic [127:0] vals;
  int           seq;
  int           idx;
  int           ea;
  logic [3:0]   v0;
  logic [3:0]   rdy;
  logic [15:0]  r0hist;
  logic [15:0]  ord;
  logic [3:0]   got[$];
  logic         fl;

  initial begin
    tbl[0] = '{4'b1010, 16'h3010, {32'h33, 32'h0, 32'h11, 32'h0}, 74'h0};
    tbl[1] = '{4'b0000, 16'h0, 128'h0, {1'b1, 1'b1, 4'h1, 32'h11, 4'h3, 32'h33}};
    tbl[2] = '{4'b0100, 16'h0500, {32'h0, 32'hDEADBEEF, 64'h0}, {1'b0, 1'b0, 4'h1, 32'h11, 4'h3, 32'h33}};
    tbl[3] = '{4'b0000, 16'h0, 128'h0, {1'b1, 1'b0, 4'h5, 32'hDEADBEEF, 4'h3, 32'h33}};
    tbl[4] = '{4'b1001, 16'hE007, {32'hEE, 64'h0, 32'h77}, {1'b0, 1'b0, 4'h5, 32'hDEADBEEF, 4'h3, 32'h33}};
    tbl[5] = '{4'b0000, 16'h0, 128'h0, {1'b1, 1'b1, 4'hE, 32'hEE, 4'h7, 32'h77}};
    tbl[6] = '{4'b0011, 16'h0098, {64'h0, 32'h99, 32'h88}, {1'b0, 1'b0, 4'hE, 32'hEE, 4'h7, 32'h77}};
    tbl[7] = '{4'b0000, 16'h0, 128'h0, {1'b1, 1'b1, 4'h9, 32'h99, 4'h8, 32'h88}};
    tbl[8] = '{4'b1100, 16'hDC00, {32'hDD, 32'hCC, 64'h0}, {1'b0, 1'b0, 4'h9, 32'h99, 4'h8, 32'h88}};
    tbl[9] = '{4'b0000, 16'h0, 128'h0, {1'b1, 1'b1, 4'hC, 32'hCC, 4'hD, 32'hDD}};

    resetn    = 1'b0;
    src_valid = '0;
    src_rob   = '0;
    src_value = '0;
    flush     = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk("reset_out", outv(), 128'd0);
    chk("reset_rdy", 128'(src_ready), 128'(4'hF));
    #1 resetn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      src_valid = tbl[i].v;
      src_rob   = tbl[i].rob;
      src_value = tbl[i].val;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), outv(), {54'd0, tbl[i].exp});
    end
    src_valid = '0;

    // Mid-stream reset while a broadcast is on the outputs and entries are still queued.
    do_reset();
    cycle(4'hF, 16'h4321, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b0);
    cycle(4'hF, 16'h8765, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(4'h0, 16'h0, 128'h0, 1'b0);
    cycle(4'b0010, 16'h00A0, {64'h0, 32'h1234_5678, 32'h0}, 1'b0);
    for (int i = 0; i < 2; i++) cycle(4'h0, 16'h0, 128'h0, 1'b0);

    // Source 0 fills while the pointer favours sources 2 and 3.
    do_reset();
    cycle(4'b0010, 16'h0010, {64'h0, 32'h1000_0000, 32'h0}, 1'b0);
    cycle(4'h0, 16'h0, 128'h0, 1'b0);
    idx    = 0;
    seq    = 1;
    r0hist = '0;
    got.delete();
    for (int c = 0; c < 16; c++) begin
      for (int s = 0; s < 4; s++) vals[32*s +: 32] = {4'(s), 28'(seq + s)};
      seq += 4;
      v0 = {3'b111, (idx < 3)};
      rdy = m_ready(1'b0);
      r0hist[c] = src_ready[0];
      cycle(v0, {12'($urandom), 4'(idx + 1)}, vals, 1'b0);
      if (wea && dina_value[31:28] == 4'h0) got.push_back(dina_rob);
      if (web && dinb_value[31:28] == 4'h0) got.push_back(dinb_rob);
      if (v0[0] && rdy[0]) idx++;
    end
    chk("full_ready_seq", 128'(r0hist[3:0]), 128'(4'b1011));
    ord = '0;
    foreach (got[i]) ord = {ord[11:0], got[i]};
    chk("src0_order", 128'(ord), 128'(16'h0123));
    for (int i = 0; i < 6; i++) cycle(4'h0, 16'h0, 128'h0, 1'b0);

    // All sources always valid: grant pairs alternate (0,1),(2,3).
    do_reset();
    for (int c = 0; c < 64; c++) begin
      for (int s = 0; s < 4; s++) vals[32*s +: 32] = {4'(s), 28'(seq + s)};
      seq += 4;
      cycle(4'hF, 16'($urandom), vals, 1'b0);
      if (c >= 1) begin
        ea = (c % 2 == 1) ? 0 : 2;
        chk("fair", 128'({wea, web, dina_value[31:28], dinb_value[31:28]}),
            128'({2'b11, 4'(ea), 4'(ea + 1)}));
      end
    end
    for (int i = 0; i < 6; i++) cycle(4'h0, 16'h0, 128'h0, 1'b0);

`ifdef ISSUE_WAKEUP_FLUSH_EN
    // Flush with three sources holding entries: nothing queued before it may appear.
    do_reset();
    cycle(4'b0001, 16'h000F, {96'h0, 32'hF0F0}, 1'b0);
    cycle(4'h0, 16'h0, 128'h0, 1'b0);
    cycle(4'b0111, 16'h0321, {32'h0, 32'hC3, 32'hC2, 32'hC1}, 1'b0);
    cycle(4'b0111, 16'h0654, {32'h0, 32'hC6, 32'hC5, 32'hC4}, 1'b1);
    chk("flush_quiet", 128'({wea, web}), 128'(2'b00));
    for (int i = 0; i < 4; i++) cycle(4'h0, 16'h0, 128'h0, 1'b0);
`endif

    do_reset();
    for (int c = 0; c < 400; c++) begin
      vals = {$urandom, $urandom, $urandom, $urandom};
`ifdef ISSUE_WAKEUP_FLUSH_EN
      fl = ($urandom_range(0, 15) == 0);
`else
      fl = 1'b0;
`endif
      cycle(4'($urandom_range(0, 15)), 16'($urandom), vals, fl);
    end
    for (int i = 0; i < 6; i++) cycle(4'h0, 16'h0, 128'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
